// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants for the rvseed ID-stage hazard scoreboard.
//   DEF_REG_ADDR_WIDTH : default architectural register address width
//   X0_REG             : index of the hard-wired zero register, never tracked
//   SB_PEND_W          : default pending-write counter width
package id_hazard_scoreboard_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int X0_REG             = 0;
  localparam int SB_PEND_W          = 2;

endpackage

// File: rtl/id_hazard_scoreboard_sb_pend_cnt.sv
// Pending-write counter for one architectural register.
//   clk, rst : clock, synchronous active-high reset
//   clr      : drop all pending writes (flush); wins over inc/dec_cnt
//   inc      : one new write issued this cycle
//   dec_cnt  : number of write-backs retiring this register this cycle
//   cnt      : current pending count
//   nz       : cnt != 0
//   under    : more retires requested than pending writes (count clamps at 0)
module sb_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [PEND_W:0]   dec_cnt,
  output logic [PEND_W-1:0] cnt,
  output logic              nz,
  output logic              under
);

  localparam logic [PEND_W:0] CNT_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [PEND_W:0] avail;
  logic [PEND_W:0] cnt_next;

  // One extra bit so pend+inc and the wb multiplicity never wrap before clamping.
  assign avail = {1'b0, cnt} + {{PEND_W{1'b0}}, inc};
  assign under = ~clr & (dec_cnt > avail);
  assign nz    = (cnt != '0);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = '0;
    if (dec_cnt < avail) begin
      cnt_next = avail - dec_cnt;
    end
    if (cnt_next > CNT_MAX) begin
      cnt_next = CNT_MAX;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next[PEND_W-1:0];
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// RAW-hazard scoreboard for the ID stage. Tracks outstanding writes per register
// and stalls ID while a source operand still has a write in flight.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : clear all pending state; same-cycle issue/wb are dropped
//   rs_valid      : per-port source operand in use
//   rs_addr       : packed source addresses, port i at [i*RAW +: RAW]
//   issue_valid   : instruction in ID wants to leave
//   issue_we      : instruction writes issue_rd
//   issue_rd      : destination register
//   wb_valid      : per-channel write-back this cycle
//   wb_rd         : packed write-back addresses
//   stall         : combinational hold of ID (RAW hazard or counter full)
//   issue_fire    : issue_valid & ~stall
//   busy_vec      : registered, bit r set while reg r has pending writes
//   err_underflow : sticky, write-back to a register with nothing pending
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_RS         = 2,
  parameter int NUM_WB         = 2,
  parameter int PEND_W         = SB_PEND_W,
  parameter bit WB_BYPASS      = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_RS-1:0]                rs_valid,
  input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic                             issue_valid,
  input  logic                             issue_we,
  input  logic [REG_ADDR_WIDTH-1:0]        issue_rd,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB*REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                             stall,
  output logic                             issue_fire,
  output logic [2**REG_ADDR_WIDTH-1:0]     busy_vec,
  output logic                             err_underflow
);

  localparam int RAW      = REG_ADDR_WIDTH;
  localparam int NUM_REGS = 2**RAW;
  localparam int CNT_W    = PEND_W + 1;
  localparam logic [RAW-1:0]    X0       = RAW'(X0_REG);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_REGS-1:0]             retire;
  logic [NUM_REGS-1:1]             under_vec;
  logic [NUM_RS-1:0]               hazard;
  logic                            full;

  // x0 is never tracked: it always reads as idle and never retires.
  assign pend[0]     = '0;
  assign retire[0]   = 1'b0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] dec_cnt;

    // Write-back multiplicity for this register across all channels.
    always_comb begin
      dec_cnt = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_rd[k*RAW +: RAW] == RAW'(r))) begin
          dec_cnt = dec_cnt + CNT_W'(1);
        end
      end
    end

    assign retire[r] = (dec_cnt != '0);

    sb_pend_cnt #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .inc     (issue_fire & issue_we & (issue_rd == RAW'(r))),
      .dec_cnt (dec_cnt),
      .cnt     (pend[r]),
      .nz      (busy_vec[r]),
      .under   (under_vec[r])
    );
  end

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      logic [RAW-1:0] a;
      a = rs_addr[i*RAW +: RAW];
      if (rs_valid[i] && (a != X0) && (pend[a] != '0)) begin
        hazard[i] = 1'b1;
        // The last pending write retiring this cycle is forwarded, so no stall.
        if (WB_BYPASS && (pend[a] == PEND_W'(1)) && retire[a]) begin
          hazard[i] = 1'b0;
        end
      end
    end
  end

  // A full counter may still accept an issue when the same register retires this cycle.
  assign full = issue_we && (issue_rd != X0) && (pend[issue_rd] == PEND_MAX) && !retire[issue_rd];

  assign stall      = issue_valid & ((|hazard) | full);
  assign issue_fire = issue_valid & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (|under_vec) begin
      err_underflow <= 1'b1;
    end
  end

endmodule
